pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath payload width in bits (pc/inst/operands packed by the instantiating stage).
REQ-002 The block SHALL have parameter CTRL_W, default 16, giving the control payload width in bits (alu_sel/wb_sel/regwen etc.).
REQ-003 The block SHALL have parameter CTRL_BUBBLE, default {CTRL_W{1'b0}}, giving the control value that marks a bubble (no regwen, no memrw).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port i_clk  input  1  SHALL be the single rising-edge clock.
REQ-006 Port i_reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 Port i_flush  input  1  SHALL be the synchronous kill of all held entries.
REQ-008 Port i_valid  input  1  SHALL indicate that the upstream stage presents an entry.
REQ-009 Port o_ready  output  1  SHALL indicate that this stage accepts an entry in the current cycle.
REQ-010 Port i_data  input  DATA_W  SHALL carry the upstream data payload.
REQ-011 Port i_ctrl  input  CTRL_W  SHALL carry the upstream control payload.
REQ-012 Port o_valid  output  1  SHALL indicate that an entry is presented downstream.
REQ-013 Port i_ready  input  1  SHALL indicate that the downstream stage accepts the presented entry.
REQ-014 Port o_data  output  DATA_W  SHALL carry the downstream data payload.
REQ-015 Port o_ctrl  output  CTRL_W  SHALL carry the downstream control payload.
REQ-016 Port o_count  output  2  SHALL carry the number of held entries (0..2).

Function
REQ-017 The block SHALL be a 2-entry skid buffer (main register drives the outputs; skid register absorbs one entry), with states EMPTY, ONE and TWO.
- Accept event: i_valid && o_ready.
- Drain event: o_valid && i_ready.
REQ-018 o_valid SHALL be (state != EMPTY), o_ready SHALL be (state != TWO), and o_count SHALL equal the state encoding; all three SHALL be registered-state decodes with no combinational path from i_ready or i_valid.
REQ-019 EMPTY: on accept, main SHALL load the input -> ONE; otherwise the state SHALL hold.
REQ-020 ONE, transitions:
- accept and drain -> main SHALL load the input, state stays ONE;
- accept only -> skid SHALL load the input -> TWO;
- drain only -> EMPTY;
- neither -> hold.
REQ-021 TWO: on drain, main SHALL load the skid -> ONE; no accept is possible in TWO.
REQ-022 Latency SHALL be 1 cycle from accept to o_valid when the block is EMPTY, and throughput SHALL be 1 entry per cycle when i_ready is held high.
REQ-023 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-024 On every transition into EMPTY, o_ctrl SHALL be loaded with CTRL_BUBBLE and o_data SHALL hold its last value.
REQ-025 Flush SHALL take priority over every handshake in the same cycle:
- next state SHALL be EMPTY;
- o_ctrl SHALL be CTRL_BUBBLE and o_data SHALL be 0;
- any input accepted in that cycle SHALL be discarded;
- a drain in that cycle SHALL still count as consumed downstream.
REQ-026 Entry contents SHALL never be modified in flight; payload widths SHALL pass through unchanged.

Reset
REQ-027 While i_reset is high, the block SHALL asynchronously force: state EMPTY, o_valid 0, o_ready 1, o_count 0, o_data 0, o_ctrl CTRL_BUBBLE, skid contents 0.
REQ-028 Reset asserted mid-transfer SHALL discard all entries, and the first cycle after deassertion SHALL behave as EMPTY.

Configuration
REQ-029 When PIPE_SKID_PERF_EN is defined, the block SHALL add two output ports:
- o_stall_cnt  output  16  SHALL count cycles with o_valid && !i_ready;
- o_bubble_cnt  output  16  SHALL count cycles with !o_valid.
Both counters SHALL saturate at 16'hFFFF, SHALL be cleared by reset only, and SHALL be unaffected by flush.
REQ-030 When PIPE_SKID_PERF_EN is not defined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Streaming: i_ready=1, i_valid=1 with data 1,2,3,4 on consecutive cycles -> o_data 1,2,3,4 one cycle later each, o_count stays 1.
REQ-032 Backpressure: send A,B with i_ready=0 -> o_count=2, o_ready=0, o_data=A; raise i_ready -> A then B drained, o_count 2->1->0.
REQ-033 Flush in TWO with i_valid=1 (C) -> next cycle o_valid=0, o_ctrl=CTRL_BUBBLE, o_data=0, o_ready=1; C never appears.
REQ-034 Drain to empty: single entry ctrl=16'h00FF, then drain -> o_ctrl=CTRL_BUBBLE, o_valid=0.
REQ-035 Async reset pulse between clock edges while o_count=2 -> outputs reach reset values before the next edge.
REQ-036 With PIPE_SKID_PERF_EN defined: 5 cycles stalled then 3 cycles empty -> o_stall_cnt=5, o_bubble_cnt=3 (beyond the post-reset idle count); saturation is checked at 65535.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with flush and bubble insertion.
// Optional performance counters are enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_stage #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_count
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [15:0]       o_stall_cnt,
    output logic [15:0]       o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              accept;
    logic              drain;

    // Handshake outputs decode registered state only.
    assign o_valid = (state_q != EMPTY);
    assign o_ready = (state_q != TWO);
    assign o_count = state_q;
    assign o_data  = main_data_q;
    assign o_ctrl  = main_ctrl_q;

    assign accept = i_valid && o_ready;
    assign drain  = o_valid && i_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (i_flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = CTRL_BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_d = i_data;
                        main_ctrl_d = i_ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data_d = i_data;
                        main_ctrl_d = i_ctrl;
                    end else if (accept) begin
                        skid_data_d = i_data;
                        skid_ctrl_d = i_ctrl;
                        state_d     = TWO;
                    end else if (drain) begin
                        main_ctrl_d = CTRL_BUBBLE;
                        state_d     = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = CTRL_BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] bubble_cnt_q;

    // Saturating counters; flush intentionally does not clear them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (o_valid && !i_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (!o_valid && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: stimulus pushes expected entries,
// a negedge monitor pops and compares on every downstream drain.
module tb_pipe_skid_stage;

    localparam logic [15:0] BUB = 16'hB0B0;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] c;
    } ent_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic [15:0] i_ctrl = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data;
    logic [15:0] o_ctrl;
    logic [1:0]  o_count;
`ifdef PIPE_SKID_PERF_EN
    logic [15:0] o_stall_cnt;
    logic [15:0] o_bubble_cnt;
`endif

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipe_skid_stage #(
        .DATA_W      (32),
        .CTRL_W      (16),
        .CTRL_BUBBLE (BUB)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_ctrl  (i_ctrl),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_ctrl  (o_ctrl),
        .o_count (o_count)
`ifdef PIPE_SKID_PERF_EN
        ,
        .o_stall_cnt  (o_stall_cnt),
        .o_bubble_cnt (o_bubble_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [15:0] c, input bit expect_accept);
        i_valid = 1'b1;
        i_data  = d;
        i_ctrl  = c;
        if (expect_accept) exp_q.push_back('{d: d, c: c});
    endtask

    // Monitor: a drain happens at the next posedge whenever o_valid && i_ready.
    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {o_data, o_ctrl}, 48'h0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_entry", {o_data, o_ctrl}, {e.d, e.c});
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 48'(o_valid), 48'd0);
        chk("rst_ready", 48'(o_ready), 48'd1);
        chk("rst_count", 48'(o_count), 48'd0);
        chk("rst_data_ctrl", {o_data, o_ctrl}, {32'h0, BUB});
        i_reset = 1'b0;

        // Streaming at full throughput
        i_ready = 1'b1;
        for (int unsigned k = 1; k <= 4; k++) begin
            send(32'(k), 16'(16'h0010 + k), 1'b1);
            tick();
            chk("stream_data", 48'(o_data), 48'(k));
            chk("stream_count", 48'(o_count), 48'd1);
        end
        i_valid = 1'b0;
        tick();
        chk("empty_valid", 48'(o_valid), 48'd0);
        chk("empty_bubble_hold", {o_data, o_ctrl}, {32'd4, BUB});

        // Backpressure fills skid, TWO rejects input
        i_ready = 1'b0;
        send(32'hAAAA_0001, 16'h0A0A, 1'b1);
        tick();
        chk("bp_count1", 48'(o_count), 48'd1);
        send(32'hBBBB_0002, 16'h0B0B, 1'b1);
        tick();
        chk("bp_count2", 48'(o_count), 48'd2);
        chk("bp_ready", 48'(o_ready), 48'd0);
        chk("bp_dataA", 48'(o_data), 48'hAAAA_0001);
        send(32'hDEAD_BEEF, 16'hDEAD, 1'b0);
        tick();
        chk("bp_hold_count", 48'(o_count), 48'd2);
        chk("bp_hold_data", 48'(o_data), 48'hAAAA_0001);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("bp_drain_count", 48'(o_count), 48'd1);
        chk("bp_dataB", {o_data, o_ctrl}, {32'hBBBB_0002, 16'h0B0B});
        tick();
        chk("bp_empty_count", 48'(o_count), 48'd0);

        // Flush in TWO with a concurrent input that must be discarded
        i_ready = 1'b0;
        send(32'hD000_0001, 16'h0D01, 1'b1);
        tick();
        send(32'hE000_0002, 16'h0E02, 1'b1);
        tick();
        send(32'hC000_0003, 16'h0C03, 1'b0);
        i_flush = 1'b1;
        tick();
        exp_q.delete();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_valid", 48'(o_valid), 48'd0);
        chk("flush_data_ctrl", {o_data, o_ctrl}, {32'h0, BUB});
        chk("flush_ready", 48'(o_ready), 48'd1);
        chk("flush_count", 48'(o_count), 48'd0);
        i_ready = 1'b1;
        repeat (2) tick();

        // Flush while draining: drained entry still counts as consumed
        i_ready = 1'b0;
        send(32'hF000_0004, 16'h0F04, 1'b1);
        tick();
        send(32'h6000_0005, 16'h0605, 1'b0);
        i_ready = 1'b1;
        i_flush = 1'b1;
        tick();
        chk("flushdrain_sb_empty", 48'(exp_q.size()), 48'd0);
        exp_q.delete();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flushdrain_valid", 48'(o_valid), 48'd0);

        // Drain to empty loads the bubble and holds data
        i_ready = 1'b0;
        send(32'h0000_0055, 16'h00FF, 1'b1);
        tick();
        chk("single_ctrl", 48'(o_ctrl), 48'h00FF);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("drain_empty_valid", 48'(o_valid), 48'd0);
        chk("drain_empty_dc", {o_data, o_ctrl}, {32'h55, BUB});

        // Async reset pulse between edges while holding two entries
        i_ready = 1'b0;
        send(32'h1111_0007, 16'h0107, 1'b1);
        tick();
        send(32'h2222_0008, 16'h0208, 1'b1);
        tick();
        i_valid = 1'b0;
        chk("pre_rst_count", 48'(o_count), 48'd2);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_valid_ready", {46'h0, o_valid, o_ready}, {46'h0, 1'b0, 1'b1});
        chk("arst_count", 48'(o_count), 48'd0);
        chk("arst_data_ctrl", {o_data, o_ctrl}, {32'h0, BUB});
        exp_q.delete();
        tick();
        i_reset = 1'b0;
        i_ready = 1'b1;
        send(32'h3333_0009, 16'h0309, 1'b1);
        tick();
        chk("post_rst_data", 48'(o_data), 48'h3333_0009);
        chk("post_rst_count", 48'(o_count), 48'd1);
        i_valid = 1'b0;
        tick();
        chk("post_rst_empty", 48'(o_count), 48'd0);

`ifdef PIPE_SKID_PERF_EN
        begin
            logic [15:0] s0, b0;
            i_ready = 1'b0;
            send(32'h4444_000A, 16'h040A, 1'b1);
            tick();
            i_valid = 1'b0;
            s0 = o_stall_cnt;
            b0 = o_bubble_cnt;
            repeat (5) tick();
            i_ready = 1'b1;
            tick();
            repeat (3) tick();
            chk("perf_stall", 48'(o_stall_cnt), 48'(s0 + 16'd5));
            chk("perf_bubble", 48'(o_bubble_cnt), 48'(b0 + 16'd3));
            repeat (65540) @(posedge i_clk);
            #1;
            chk("perf_bubble_sat", 48'(o_bubble_cnt), 48'hFFFF);
            chk("perf_stall_keep", 48'(o_stall_cnt), 48'(s0 + 16'd5));
        end
`endif

        tick();
        chk("sb_final_empty", 48'(exp_q.size()), 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
